// File: rtl/imm_decode_stage.sv
// imm_decode_stage: pipelined RISC-V immediate generator for the decode stage.
// Decodes the immediate selected by in_immsrc from in_instr, sign- or
// zero-extends it to XLEN bits and registers it with the sideband tag.
// A 2-entry skid buffer (output register + skid register) sustains one
// transfer per cycle under output backpressure while keeping in_ready
// registered.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_valid/in_ready            upstream handshake
//   in_instr, in_immsrc, in_tag  instruction, format select, sideband tag
//   out_valid/out_ready          downstream handshake
//   out_imm, out_tag, out_err    extended immediate, tag, illegal-format flag
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_decode_stage: XLEN must be 32 or 64");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL1,
    ST_FULL2
  } state_e;

  // Opcode bits are not part of any immediate.
  logic unused_opcode;
  assign unused_opcode = ^in_instr[6:0];

  // ---------------------------------------------------------------------
  // Immediate decode. Every format is first assembled as a 32-bit value;
  // the signed formats are then sign-extended to XLEN, the rest zero-extended.
  // ---------------------------------------------------------------------
  logic [31:0]     imm32;
  logic            imm_sx;
  logic            dec_err;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    imm32   = '0;
    imm_sx  = 1'b1;
    dec_err = 1'b0;
    unique case (in_immsrc)
      3'b000: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      3'b001: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      3'b010: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
      3'b011: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
      3'b100: imm32 = {in_instr[31:12], 12'b0};
      3'b101: begin
        imm_sx = 1'b0;
        imm32  = (XLEN == 64) ? {26'b0, in_instr[25:20]} : {27'b0, in_instr[24:20]};
      end
      3'b110: begin
        imm_sx = 1'b0;
        imm32  = {27'b0, in_instr[19:15]};
      end
      default: begin
        imm_sx  = 1'b0;
        dec_err = 1'b1;
      end
    endcase
    dec_imm = imm_sx ? XLEN'(signed'(imm32)) : XLEN'(imm32);
  end

  // ---------------------------------------------------------------------
  // Skid-buffer control
  // ---------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [XLEN-1:0]  or_imm_q, or_imm_d, sk_imm_q, sk_imm_d;
  logic [TAG_W-1:0] or_tag_q, or_tag_d, sk_tag_q, sk_tag_d;
  logic             or_err_q, or_err_d, sk_err_q, sk_err_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             accept;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d  = state_q;
    or_imm_d = or_imm_q;
    or_tag_d = or_tag_q;
    or_err_d = or_err_q;
    sk_imm_d = sk_imm_q;
    sk_tag_d = sk_tag_q;
    sk_err_d = sk_err_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          or_imm_d = dec_imm;
          or_tag_d = in_tag;
          or_err_d = dec_err;
          state_d  = ST_FULL1;
        end
      end
      ST_FULL1: begin
        if (out_ready && accept) begin
          or_imm_d = dec_imm;
          or_tag_d = in_tag;
          or_err_d = dec_err;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          sk_imm_d = dec_imm;
          sk_tag_d = in_tag;
          sk_err_d = dec_err;
          state_d  = ST_FULL2;
        end
      end
      ST_FULL2: begin
        if (out_ready) begin
          or_imm_d = sk_imm_q;
          or_tag_d = sk_tag_q;
          or_err_d = sk_err_q;
          state_d  = ST_FULL1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Handshake flags are derived from the next state so both are plain flops.
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      or_imm_q    <= '0;
      or_tag_q    <= '0;
      or_err_q    <= 1'b0;
      sk_imm_q    <= '0;
      sk_tag_q    <= '0;
      sk_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      or_imm_q    <= or_imm_d;
      or_tag_q    <= or_tag_d;
      or_err_q    <= or_err_d;
      sk_imm_q    <= sk_imm_d;
      sk_tag_q    <= sk_tag_d;
      sk_err_q    <= sk_err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_imm   = or_imm_q;
  assign out_tag   = or_tag_q;
  assign out_err   = or_err_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Testbench for imm_decode_stage: one XLEN=32 and one XLEN=64 instance
// driven by identical inputs, checked against a queue-based reference.
module tb_imm_decode_stage;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      in_instr = '0;
  logic [2:0]       in_immsrc = '0;
  logic [TAG_W-1:0] in_tag = '0;

  logic             in_ready32, out_valid32, out_err32;
  logic [31:0]      out_imm32;
  logic [TAG_W-1:0] out_tag32;
  logic             in_ready64, out_valid64, out_err64;
  logic [63:0]      out_imm64;
  logic [TAG_W-1:0] out_tag64;

  imm_decode_stage #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_tag(out_tag32), .out_err(out_err32));

  imm_decode_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_err(out_err64));

  typedef struct {
    logic [31:0]      instr;
    logic [2:0]       src;
    logic [TAG_W-1:0] tag;
    logic [31:0]      e32;
    logic [63:0]      e64;
    logic             err;
  } vec_t;

  typedef struct {
    logic [31:0]      e32;
    logic [63:0]      e64;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t q[$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Field values reassembled with arithmetic, then interpreted as a signed
  // number of the format's width.
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] src,
                                          input bit is64);
    longint f = 0;
    longint val;
    int bits = 1;
    bit zext = 1'b0;
    case (src)
      3'd0: begin f = longint'(i[31:20]); bits = 12; end
      3'd1: begin f = longint'(i[31:25]) * 32 + longint'(i[11:7]); bits = 12; end
      3'd2: begin
        f = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
          + longint'(i[11:8]) * 2;
        bits = 13;
      end
      3'd3: begin
        f = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
          + longint'(i[30:21]) * 2;
        bits = 21;
      end
      3'd4: begin f = longint'(i[31:12]) * 4096; bits = 32; end
      3'd5: begin f = is64 ? longint'(i[25:20]) : longint'(i[24:20]); zext = 1'b1; end
      3'd6: begin f = longint'(i[19:15]); zext = 1'b1; end
      default: begin f = 0; zext = 1'b1; end
    endcase
    if (!zext && f >= (longint'(1) << (bits - 1))) val = f - (longint'(1) << bits);
    else val = f;
    if (is64) return 64'(val);
    return {32'b0, val[31:0]};
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] i, input logic [2:0] src,
                                  input logic [TAG_W-1:0] tag);
    exp_t e;
    logic [63:0] t;
    t     = ref_imm(i, src, 1'b0);
    e.e32 = t[31:0];
    e.e64 = ref_imm(i, src, 1'b1);
    e.tag = tag;
    e.err = (src == 3'b111);
    return e;
  endfunction

  task automatic check_outputs();
    chk("in_ready32", in_ready32, q.size() < 2);
    chk("in_ready64", in_ready64, q.size() < 2);
    chk("out_valid32", out_valid32, q.size() > 0);
    chk("out_valid64", out_valid64, q.size() > 0);
    if (q.size() > 0) begin
      chk("imm32", out_imm32, q[0].e32);
      chk("imm64", out_imm64, q[0].e64);
      chk("tag32", out_tag32, q[0].tag);
      chk("tag64", out_tag64, q[0].tag);
      chk("err32", out_err32, q[0].err);
      chk("err64", out_err64, q[0].err);
    end
  endtask

  // One clock: update the reference at the rising edge, check at the falling.
  task automatic step();
    bit can_take;
    @(posedge clk);
    can_take = (q.size() < 2);
    if (out_ready && q.size() > 0) void'(q.pop_front());
    if (in_valid && can_take) q.push_back(mk_exp(in_instr, in_immsrc, in_tag));
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [2:0] s,
                       input logic [TAG_W-1:0] t);
    in_valid  = v;
    in_instr  = i;
    in_immsrc = s;
    in_tag    = t;
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{32'hFFF00093, 3'd0, 5'd3, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tbl[1] = '{32'hFE20AE23, 3'd1, 5'd4, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    tbl[2] = '{32'hFE000CE3, 3'd2, 5'd5, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0};
    tbl[3] = '{32'h008000EF, 3'd3, 5'd6, 32'h00000008, 64'h0000000000000008, 1'b0};
    tbl[4] = '{32'h123452B7, 3'd4, 5'd7, 32'h12345000, 64'h0000000012345000, 1'b0};
    tbl[5] = '{32'h800002B7, 3'd4, 5'd8, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    tbl[6] = '{32'h03F00013, 3'd5, 5'd9, 32'h0000001F, 64'h000000000000003F, 1'b0};
    tbl[7] = '{32'h000F8073, 3'd6, 5'd10, 32'h0000001F, 64'h000000000000001F, 1'b0};
    tbl[8] = '{32'hFFFFFFFF, 3'd7, 5'd11, 32'h00000000, 64'h0000000000000000, 1'b1};
    tbl[9] = '{32'h00100093, 3'd0, 5'd12, 32'h00000001, 64'h0000000000000001, 1'b0};

    // Reset state while reset_n is low.
    repeat (2) @(negedge clk);
    chk("rst_valid32", out_valid32, 1'b0);
    chk("rst_valid64", out_valid64, 1'b0);
    chk("rst_imm32", out_imm32, 32'h0);
    chk("rst_imm64", out_imm64, 64'h0);
    chk("rst_tag32", out_tag32, '0);
    chk("rst_err32", out_err32, 1'b0);
    reset_n = 1'b1;
    step();

    // Back-to-back table vectors with out_ready held high.
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, tbl[k].instr, tbl[k].src, tbl[k].tag);
      step();
      chk("tbl_valid", out_valid32, 1'b1);
      chk("tbl_imm32", out_imm32, tbl[k].e32);
      chk("tbl_imm64", out_imm64, tbl[k].e64);
      chk("tbl_tag", out_tag32, tbl[k].tag);
      chk("tbl_err", out_err32, tbl[k].err);
    end
    drive(1'b0, '0, '0, '0);
    step();
    chk("drain_valid", out_valid32, 1'b0);

    // Backpressure: three offers with out_ready low, only two accepted.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'd0, 5'd1);
    step();
    drive(1'b1, 32'hFE20AE23, 3'd1, 5'd2);
    step();
    chk("bp_ready_low", in_ready32, 1'b0);
    drive(1'b1, 32'h123452B7, 3'd4, 5'd3);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_imm", out_imm32, 32'hFFFFFFFF);
      chk("bp_hold_tag", out_tag32, 5'd1);
      chk("bp_ready_low2", in_ready32, 1'b0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_second_imm", out_imm32, 32'hFFFFFFFC);
    chk("bp_second_tag", out_tag32, 5'd2);
    chk("bp_ready_up", in_ready32, 1'b1);
    step();
    chk("bp_third_imm", out_imm32, 32'h12345000);
    chk("bp_third_tag", out_tag32, 5'd3);
    drive(1'b0, '0, '0, '0);
    step();
    chk("bp_empty", out_valid32, 1'b0);

    // Reset asserted mid-cycle while both entries are occupied.
    out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 3'd0, 5'd20);
    step();
    drive(1'b1, 32'h00600093, 3'd0, 5'd21);
    step();
    chk("pre_rst_full", in_ready32, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid32", out_valid32, 1'b0);
    chk("mid_rst_valid64", out_valid64, 1'b0);
    chk("mid_rst_imm32", out_imm32, 32'h0);
    chk("mid_rst_imm64", out_imm64, 64'h0);
    q.delete();
    @(negedge clk);
    drive(1'b0, '0, '0, '0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
            TAG_W'($urandom));
      out_ready = (n % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step();
    end
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
